// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// regfile_scoreboard: parametrised register file with busy-bit scoreboard and
// debug tap. Optional macro: REGFILE_BYPASS_EN (write-through read forwarding).
// Revision: 1.0
// ============================================================================
module regfile_scoreboard #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_RD        = 2,
    parameter int unsigned DBG_REG       = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data_o,
    output logic [NUM_RD-1:0]               rd_busy_o,
    input  logic                            we_i,
    input  logic [ADDRESS_WIDTH-1:0]        wr_addr_i,
    input  logic [DATA_WIDTH-1:0]           wr_data_i,
    input  logic                            iss_valid_i,
    input  logic [ADDRESS_WIDTH-1:0]        iss_rd_i,
    output logic [ADDRESS_WIDTH-1:0]        busy_cnt_o,
    output logic [DATA_WIDTH-1:0]           dbg_o
);

    localparam int unsigned NUM_REGS = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0]      busy;
    logic [NUM_REGS-1:0]      busy_next;
    logic [ADDRESS_WIDTH-1:0] busy_cnt;
    logic [ADDRESS_WIDTH-1:0] cnt_next;
    logic                     wr_en;
    logic                     iss_en;

    // x0 is hard-wired: writes and issues to it are dropped here.
    assign wr_en  = we_i && (wr_addr_i != '0);
    assign iss_en = iss_valid_i && (iss_rd_i != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr_i] <= wr_data_i;
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_addr_i] = 1'b0;
        end
        if (iss_en) begin
            busy_next[iss_rd_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            cnt_next = cnt_next + ADDRESS_WIDTH'(busy_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    assign busy_cnt_o = busy_cnt;
    assign dbg_o      = regs[DBG_REG];

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] ra;
        assign ra = rd_addr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
`ifdef REGFILE_BYPASS_EN
        logic fwd;
        // Forwarding is suppressed under reset so outputs clear immediately.
        assign fwd = wr_en && !rst && (wr_addr_i == ra);
        assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] =
            (ra == '0) ? '0 : (fwd ? wr_data_i : regs[ra]);
        assign rd_busy_o[k] = (ra != '0) && !fwd && busy[ra];
`else
        assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 : regs[ra];
        assign rd_busy_o[k] = (ra != '0) && busy[ra];
`endif
    end

endmodule
`default_nettype wire
